instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch_if.sv | 15 +
 rtl/instr_prefetch.sv | 91 +++++++++
 tb/tb_instr_prefetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: program-memory read port and instruction output stream.
interface instr_prefetch_if #(parameter int CELL_BITS = 32, parameter int ADDR_BITS = 11);
    logic                 mem_req;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ack;
    logic [CELL_BITS-1:0] mem_rdata;
    logic                 out_valid;
    logic [CELL_BITS-1:0] out_data;
    logic [ADDR_BITS-1:0] out_addr;
    logic                 out_ready;
    modport master(output mem_req, mem_addr, out_valid, out_data, out_addr,
                   input mem_ack, mem_rdata, out_ready);
    modport slave(input mem_req, mem_addr, out_valid, out_data, out_addr,
                  output mem_ack, mem_rdata, out_ready);
endinterface

// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction prefetch FIFO with redirect flush and stale-read discard.
// Optional INSTR_PREFETCH_FLUSH_CNT_EN adds a saturating flush_count output.
module instr_prefetch #(
    parameter int CELL_BITS = 32,
    parameter int ADDR_BITS = 11,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [ADDR_BITS-1:0]   redirect_addr,
    instr_prefetch_if.master       bus,
    output logic [$clog2(DEPTH):0] count
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
    , output logic [15:0]          flush_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    state_t state;
    logic [ADDR_BITS-1:0] fp;
    logic [CELL_BITS-1:0] data_q [DEPTH];
    logic [ADDR_BITS-1:0] addr_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic push, pop;
    logic [PW:0] count_n;
    assign push = state == REQ && bus.mem_ack && !redirect;
    assign pop = bus.out_valid && bus.out_ready;
    assign count_n = count + (PW+1)'(push) - (PW+1)'(pop);
    assign bus.out_valid = count != '0;
    assign bus.out_data = data_q[rd_ptr];
    assign bus.out_addr = addr_q[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fp           <= '0;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                fp     <= redirect_addr;
            end else begin
                count <= count_n;
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if (push) begin
                    data_q[wr_ptr] <= bus.mem_rdata;
                    addr_q[wr_ptr] <= bus.mem_addr;
                    wr_ptr         <= wr_ptr + PW'(1);
                    fp             <= fp + ADDR_BITS'(1);
                end
            end
            case (state)
                IDLE: if (!redirect && count < FULL) begin
                    state        <= REQ;
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= fp;
                end
                REQ: if (bus.mem_ack) begin
                    // back-to-back request to the next sequential word while space remains
                    if (!redirect && count_n < FULL) bus.mem_addr <= fp + ADDR_BITS'(1);
                    else begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                    end
                end else if (redirect) state <= DISCARD;
                DISCARD: if (bus.mem_ack) begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) flush_count <= '0;
        else if (redirect && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed and random checks of instr_prefetch against a queue-based reference model.
module tb_instr_prefetch;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic redirect = 1'b0;
    logic [10:0] redirect_addr = '0;
    logic [2:0] count;
    int total = 0, passed = 0, errs = 0;
    int lat = 0;
    logic [10:0] q[$];
    logic [10:0] fp = '0, req_addr = '0;
    bit outstanding = 0, stale = 0;
    int age = 0;
    logic [15:0] fc = '0;
    instr_prefetch_if #(.CELL_BITS(32), .ADDR_BITS(11)) bus();
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
    logic [15:0] flush_count;
    instr_prefetch #(.CELL_BITS(32), .ADDR_BITS(11), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
        .bus(bus), .count(count), .flush_count(flush_count));
`else
    instr_prefetch #(.CELL_BITS(32), .ADDR_BITS(11), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
        .bus(bus), .count(count));
`endif
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [10:0] a);
        return {a, 21'h0} ^ (32'h9E3779B9 * {21'h0, a}) ^ 32'h13579BDF;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model_edge();
        int n;
        bit issue;
        if (rst) begin
            q.delete();
            fp = '0;
            outstanding = 0;
            stale = 0;
            fc = '0;
            return;
        end
        if (redirect && fc != 16'hFFFF) fc++;
        n = q.size();
        if (redirect) begin
            q.delete();
            fp = redirect_addr;
        end else begin
            if (bus.out_ready && q.size() != 0) void'(q.pop_front());
            if (outstanding && bus.mem_ack && !stale) begin
                q.push_back(req_addr);
                fp++;
            end
        end
        if (!outstanding) issue = !redirect && n < DEPTH;
        else issue = bus.mem_ack && !stale && !redirect && q.size() < DEPTH;
        if (outstanding && bus.mem_ack) begin
            outstanding = 0;
            stale = 0;
        end else if (outstanding && redirect) stale = 1;
        if (issue) begin
            outstanding = 1;
            req_addr = fp;
            age = 0;
        end else if (outstanding) age++;
    endtask
    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_addr", 32'(bus.out_addr), 32'(q[0]));
            chk("out_data", bus.out_data, mem_word(q[0]));
        end
        chk("mem_req", 32'(bus.mem_req), 32'(outstanding));
        if (outstanding) chk("mem_addr", 32'(bus.mem_addr), 32'(req_addr));
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
        chk("flush_count", 32'(flush_count), 32'(fc));
`endif
    endtask
    task automatic step(input bit r, input bit rd, input logic [10:0] ra, input bit ack, input bit rdy);
        rst = r;
        redirect = rd;
        redirect_addr = ra;
        bus.mem_ack = ack && outstanding;
        bus.mem_rdata = bus.mem_ack ? mem_word(req_addr) : $urandom;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask
    function automatic bit due();
        return outstanding && age >= lat;
    endfunction
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bus.out_ready = 1'b0;
        repeat (2) step(1, 0, '0, 0, 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'h0);
        lat = 1;
        repeat (14) step(0, 0, '0, due(), 0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_idle", 32'(bus.mem_req), 32'd0);
        step(1, 0, '0, 0, 0);
        lat = 0;
        repeat (20) step(0, 0, '0, due(), 1);
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 50 && !(outstanding && req_addr == 11'h005); i++) step(0, 0, '0, due(), 1);
        chk("reach_0x005", 32'(bus.mem_addr), 32'h005);
        step(0, 1, 11'h100, 0, 1);
        repeat (2) step(0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 1);
        repeat (10) step(0, 0, '0, due(), 1);
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 50 && !(outstanding && q.size() == 2); i++) step(0, 0, '0, due(), 0);
        chk("two_queued", 32'(count), 32'd2);
        step(0, 1, 11'h2A5, 1, 1);
        chk("flush_count0", 32'(count), 32'd0);
        repeat (3) step(0, 0, '0, due(), 1);
        step(0, 1, 11'h7FE, 0, 1);
        repeat (8) step(0, 0, '0, due(), 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, 11'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
        repeat (70000) step(0, 1, 11'($urandom), $urandom_range(0, 1) == 1, 1);
        chk("flush_sat", 32'(flush_count), 32'hFFFF);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
